// File: rtl/layer_control.sv
// Layer sequencer for a bank of associate units: broadcasts arguments, gathers results,
// scatters errors in training mode and reduces unit feedback into one saturated vector.
module layer_control #(
    parameter int ARGD  = 2,
    parameter int UNITS = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic                        i_arg_stb,
    input  logic [8*ARGD-1:0]           i_arg_dat,
    output logic                        o_arg_rdy,
    output logic                        o_res_stb,
    output logic [16*UNITS-1:0]         o_res_dat,
    input  logic                        i_res_rdy,
    input  logic                        i_err_stb,
    input  logic [16*UNITS-1:0]         i_err_dat,
    output logic                        o_err_rdy,
    output logic                        o_fbk_stb,
    output logic [16*ARGD-1:0]          o_fbk_dat,
    input  logic                        i_fbk_rdy,
    output logic                        o_u_en,
    output logic [UNITS-1:0]            o_u_arg_stb,
    output logic [8*ARGD-1:0]           o_u_arg_dat,
    input  logic [UNITS-1:0]            i_u_arg_rdy,
    input  logic [UNITS-1:0]            i_u_res_stb,
    input  logic [16*UNITS-1:0]         i_u_res_dat,
    output logic [UNITS-1:0]            o_u_res_rdy,
    output logic [UNITS-1:0]            o_u_err_stb,
    output logic [16*UNITS-1:0]         o_u_err_dat,
    input  logic [UNITS-1:0]            i_u_err_rdy,
    input  logic [UNITS-1:0]            i_u_fbk_stb,
    input  logic [16*ARGD*UNITS-1:0]    i_u_fbk_dat,
    output logic [UNITS-1:0]            o_u_fbk_rdy
);
    localparam int CW = (UNITS > 1) ? $clog2(UNITS) : 1;

    typedef enum logic [3:0] {
        S_ARG, S_BCAST, S_GATHER, S_RES, S_ERR, S_SCAT, S_COLL, S_SUM, S_FBK
    } state_t;

    state_t                      r_state, w_next;
    logic [UNITS-1:0]            r_done, w_ack;
    logic [CW-1:0]               r_cnt;
    logic                        r_res_stb, r_fbk_stb, r_u_en;
    logic [8*ARGD-1:0]           r_u_arg_dat;
    logic [16*UNITS-1:0]         r_u_err_dat, r_res;
    logic [16*ARGD*UNITS-1:0]    r_fbk;
    logic [16*ARGD-1:0]          r_fbk_dat, w_sel, w_sat;
    logic [ARGD-1:0][23:0]       r_acc, w_sum;

    assign o_res_stb   = r_res_stb;
    assign o_res_dat   = r_res;
    assign o_fbk_stb   = r_fbk_stb;
    assign o_fbk_dat   = r_fbk_dat;
    assign o_u_en      = r_u_en;
    assign o_u_arg_dat = r_u_arg_dat;
    assign o_u_err_dat = r_u_err_dat;

    always_comb begin
        w_next      = r_state;
        w_ack       = '0;
        o_arg_rdy   = 1'b0;
        o_err_rdy   = 1'b0;
        o_u_arg_stb = '0;
        o_u_res_rdy = '0;
        o_u_err_stb = '0;
        o_u_fbk_rdy = '0;
        case (r_state)
            S_ARG: begin
                o_arg_rdy = 1'b1;
                if (i_arg_stb) w_next = S_BCAST;
            end
            S_BCAST: begin
                o_u_arg_stb = ~r_done;
                w_ack       = ~r_done & i_u_arg_rdy;
                if (&(r_done | w_ack)) w_next = S_GATHER;
            end
            S_GATHER: begin
                o_u_res_rdy = ~r_done;
                w_ack       = ~r_done & i_u_res_stb;
                if (&(r_done | w_ack)) w_next = S_RES;
            end
            S_RES: if (i_res_rdy) w_next = r_u_en ? S_ERR : S_ARG;
            S_ERR: begin
                o_err_rdy = 1'b1;
                if (i_err_stb) w_next = S_SCAT;
            end
            S_SCAT: begin
                o_u_err_stb = ~r_done;
                w_ack       = ~r_done & i_u_err_rdy;
                if (&(r_done | w_ack)) w_next = S_COLL;
            end
            S_COLL: begin
                o_u_fbk_rdy = ~r_done;
                w_ack       = ~r_done & i_u_fbk_stb;
                if (&(r_done | w_ack)) w_next = S_SUM;
            end
            S_SUM: if (r_cnt == CW'(UNITS - 1)) w_next = S_FBK;
            S_FBK: if (i_fbk_rdy) w_next = S_ARG;
            default: w_next = S_ARG;
        endcase
    end

    // Reduction datapath: one unit's feedback vector per SUM cycle, clamped on the last one.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < UNITS; i++)
            if (r_cnt == CW'(i)) w_sel = r_fbk[16*ARGD*i +: 16*ARGD];
        for (int k = 0; k < ARGD; k++) begin
            w_sum[k] = r_acc[k] + {{8{w_sel[16*k+15]}}, w_sel[16*k +: 16]};
            if ($signed(w_sum[k]) > 24'sd32767)
                w_sat[16*k +: 16] = 16'h7FFF;
            else if ($signed(w_sum[k]) < -24'sd32768)
                w_sat[16*k +: 16] = 16'h8000;
            else
                w_sat[16*k +: 16] = w_sum[k][15:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_ARG;
            r_done      <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_res_stb   <= 1'b0;
            r_fbk_stb   <= 1'b0;
            r_u_en      <= 1'b0;
            r_u_arg_dat <= '0;
            r_u_err_dat <= '0;
            r_res       <= '0;
            r_fbk       <= '0;
            r_fbk_dat   <= '0;
        end else begin
            r_state   <= w_next;
            r_res_stb <= (w_next == S_RES);
            r_fbk_stb <= (w_next == S_FBK);
            r_done    <= (w_next != r_state) ? '0 : (r_done | w_ack);
            if (r_state == S_ARG && i_arg_stb) begin
                r_u_arg_dat <= i_arg_dat;
                r_u_en      <= i_en;
            end
            if (r_state == S_ERR && i_err_stb) r_u_err_dat <= i_err_dat;
            for (int i = 0; i < UNITS; i++) begin
                if (r_state == S_GATHER && w_ack[i])
                    r_res[16*i +: 16] <= i_u_res_dat[16*i +: 16];
                if (r_state == S_COLL && w_ack[i])
                    r_fbk[16*ARGD*i +: 16*ARGD] <= i_u_fbk_dat[16*ARGD*i +: 16*ARGD];
            end
            // Accumulators idle at zero so every SUM pass starts clean.
            if (r_state == S_SUM) begin
                r_cnt <= r_cnt + CW'(1);
                r_acc <= w_sum;
                if (w_next == S_FBK) r_fbk_dat <= w_sat;
            end else begin
                r_cnt <= '0;
                r_acc <= '0;
            end
        end
    end
endmodule

// File: tb/tb_layer_control.sv
// Directed bench for layer_control (UNITS=2, ARGD=2); the bench plays upstream,
// downstream and both units, stepping cycle by cycle with hand-computed expectations.
module tb_layer_control;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic        arg_stb = 1'b0, arg_rdy;
    logic [15:0] arg_dat = '0;
    logic        res_stb, res_rdy = 1'b0;
    logic [31:0] res_dat;
    logic        err_stb = 1'b0, err_rdy;
    logic [31:0] err_dat = '0;
    logic        fbk_stb, fbk_rdy = 1'b0;
    logic [31:0] fbk_dat;
    logic        u_en;
    logic [1:0]  u_arg_stb, u_arg_rdy = '0;
    logic [15:0] u_arg_dat;
    logic [1:0]  u_res_stb = '0, u_res_rdy;
    logic [31:0] u_res_dat = '0;
    logic [1:0]  u_err_stb, u_err_rdy = '0;
    logic [31:0] u_err_dat;
    logic [1:0]  u_fbk_stb = '0, u_fbk_rdy;
    logic [63:0] u_fbk_dat = '0;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    layer_control #(.ARGD(2), .UNITS(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_arg_stb(arg_stb), .i_arg_dat(arg_dat), .o_arg_rdy(arg_rdy),
        .o_res_stb(res_stb), .o_res_dat(res_dat), .i_res_rdy(res_rdy),
        .i_err_stb(err_stb), .i_err_dat(err_dat), .o_err_rdy(err_rdy),
        .o_fbk_stb(fbk_stb), .o_fbk_dat(fbk_dat), .i_fbk_rdy(fbk_rdy),
        .o_u_en(u_en),
        .o_u_arg_stb(u_arg_stb), .o_u_arg_dat(u_arg_dat), .i_u_arg_rdy(u_arg_rdy),
        .i_u_res_stb(u_res_stb), .i_u_res_dat(u_res_dat), .o_u_res_rdy(u_res_rdy),
        .o_u_err_stb(u_err_stb), .o_u_err_dat(u_err_dat), .i_u_err_rdy(u_err_rdy),
        .i_u_fbk_stb(u_fbk_stb), .i_u_fbk_dat(u_fbk_dat), .o_u_fbk_rdy(u_fbk_rdy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [15:0] a, input logic e);
        arg_dat = a; en = e; arg_stb = 1'b1;
        tick;
        arg_stb = 1'b0; en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #2;
        chk("rst_arg_rdy", arg_rdy, 1);
        chk("rst_strobes", {res_stb, fbk_stb, err_rdy, u_en}, 0);
        chk("rst_unit_hs", {u_arg_stb, u_res_rdy, u_err_stb, u_fbk_rdy}, 0);
        chk("rst_data", {res_dat, fbk_dat}, 0);
        tick;
        rst = 1'b0;

        // inference only: staggered u_arg acks, staggered results
        accept(16'h0201, 1'b0);
        chk("t1_bcast_stb", u_arg_stb, 2'b11);
        chk("t1_arg_dat", u_arg_dat, 16'h0201);
        chk("t1_u_en", u_en, 0);
        chk("t1_arg_rdy", arg_rdy, 0);
        u_arg_rdy = 2'b01;
        tick;
        chk("t1_bcast_u0done", u_arg_stb, 2'b10);
        u_arg_rdy = 2'b00;
        tick;
        chk("t1_bcast_hold", u_arg_stb, 2'b10);
        u_arg_rdy = 2'b10;
        tick;
        u_arg_rdy = 2'b00;
        chk("t1_gather_rdy", u_res_rdy, 2'b11);
        chk("t1_bcast_off", u_arg_stb, 2'b00);
        u_res_stb = 2'b01; u_res_dat = 32'h0000_0010;
        tick;
        chk("t1_gather_u0done", u_res_rdy, 2'b10);
        chk("t1_res_stb_lo", res_stb, 0);
        u_res_stb = 2'b10; u_res_dat = 32'hFFF0_0000;
        tick;
        u_res_stb = 2'b00;
        chk("t1_res_stb", res_stb, 1);
        chk("t1_res_dat", res_dat, 32'hFFF0_0010);
        res_rdy = 1'b1;
        tick;
        res_rdy = 1'b0;
        chk("t1_res_stb_drop", res_stb, 0);
        chk("t1_back_to_arg", {arg_rdy, err_rdy}, 2'b10);

        // training pass with simultaneous acks and back-pressure on both outputs
        accept(16'h0403, 1'b1);
        chk("t2_u_en", u_en, 1);
        u_arg_rdy = 2'b11;
        tick;
        u_arg_rdy = 2'b00;
        chk("t2_gather_rdy", u_res_rdy, 2'b11);
        u_res_stb = 2'b11; u_res_dat = 32'h0002_0001;
        tick;
        u_res_stb = 2'b00;
        chk("t2_res_stb", res_stb, 1);
        chk("t2_res_dat", res_dat, 32'h0002_0001);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("t2_res_bp", {res_stb, res_dat}, {1'b1, 32'h0002_0001});
            chk("t2_res_bp_units", {u_arg_stb, u_res_rdy, u_err_stb, u_fbk_rdy, err_rdy}, 0);
        end
        res_rdy = 1'b1;
        tick;
        res_rdy = 1'b0;
        chk("t2_err_rdy", {err_rdy, res_stb}, 2'b10);
        err_stb = 1'b1; err_dat = 32'h0040_0020;
        tick;
        err_stb = 1'b0;
        chk("t2_scat_stb", u_err_stb, 2'b11);
        chk("t2_err_dat_u0", u_err_dat[15:0], 16'h0020);
        chk("t2_err_dat_u1", u_err_dat[31:16], 16'h0040);
        u_err_rdy = 2'b01;
        tick;
        chk("t2_scat_u0done", u_err_stb, 2'b10);
        u_err_rdy = 2'b10;
        tick;
        u_err_rdy = 2'b00;
        chk("t2_coll_rdy", u_fbk_rdy, 2'b11);
        u_fbk_stb = 2'b11; u_fbk_dat = 64'h0200_0003_0100_0001;
        tick;
        u_fbk_stb = 2'b00;
        chk("t2_sum_c1", {fbk_stb, u_fbk_rdy}, 0);
        tick;
        chk("t2_sum_c2", fbk_stb, 0);
        tick;
        chk("t2_fbk_stb", fbk_stb, 1);
        chk("t2_fbk_dat", fbk_dat, 32'h0300_0004);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("t2_fbk_bp", {fbk_stb, fbk_dat}, {1'b1, 32'h0300_0004});
            chk("t2_fbk_bp_units", {u_arg_stb, u_res_rdy, u_err_stb, u_fbk_rdy, arg_rdy}, 0);
        end
        fbk_rdy = 1'b1;
        tick;
        fbk_rdy = 1'b0;
        chk("t2_fbk_drop", {fbk_stb, arg_rdy}, 2'b01);

        // reversed result order and saturating feedback
        accept(16'h1111, 1'b1);
        u_arg_rdy = 2'b11;
        tick;
        u_arg_rdy = 2'b00;
        u_res_stb = 2'b10; u_res_dat = 32'h0002_0000;
        tick;
        chk("t3_gather_u1done", u_res_rdy, 2'b01);
        u_res_stb = 2'b01; u_res_dat = 32'h0000_0001;
        tick;
        u_res_stb = 2'b00;
        chk("t3_res_dat", {res_stb, res_dat}, {1'b1, 32'h0002_0001});
        res_rdy = 1'b1;
        tick;
        res_rdy = 1'b0;
        err_stb = 1'b1; err_dat = 32'h0;
        tick;
        err_stb = 1'b0;
        u_err_rdy = 2'b11;
        tick;
        u_err_rdy = 2'b00;
        u_fbk_stb = 2'b11; u_fbk_dat = 64'hFFFF_2000_8000_7000;
        tick;
        u_fbk_stb = 2'b00;
        tick;
        tick;
        chk("t3_sat_stb", fbk_stb, 1);
        chk("t3_sat_k0", fbk_dat[15:0], 16'h7FFF);
        chk("t3_sat_k1", fbk_dat[31:16], 16'h8000);
        fbk_rdy = 1'b1;
        tick;
        fbk_rdy = 1'b0;

        // reset mid-scatter, then a clean transaction
        accept(16'h0A0B, 1'b1);
        u_arg_rdy = 2'b11;
        tick;
        u_arg_rdy = 2'b00;
        u_res_stb = 2'b11; u_res_dat = 32'h0;
        tick;
        u_res_stb = 2'b00;
        res_rdy = 1'b1;
        tick;
        res_rdy = 1'b0;
        err_stb = 1'b1; err_dat = 32'h1234_5678;
        tick;
        err_stb = 1'b0;
        chk("t4_scat_stb", u_err_stb, 2'b11);
        u_err_rdy = 2'b01;
        tick;
        u_err_rdy = 2'b00;
        chk("t4_scat_partial", u_err_stb, 2'b10);
        rst = 1'b1;
        #1;
        chk("t4_rst_units", {u_arg_stb, u_res_rdy, u_err_stb, u_fbk_rdy}, 0);
        chk("t4_rst_arg_rdy", {arg_rdy, err_rdy, res_stb, fbk_stb, u_en}, 5'b10000);
        chk("t4_rst_data", {res_dat, fbk_dat}, 0);
        tick;
        rst = 1'b0;
        accept(16'h0C0D, 1'b0);
        chk("t4_next_arg", {u_en, u_arg_dat, u_arg_stb}, {1'b0, 16'h0C0D, 2'b11});
        u_arg_rdy = 2'b11;
        tick;
        u_arg_rdy = 2'b00;
        u_res_stb = 2'b11; u_res_dat = 32'h1234_5678;
        tick;
        u_res_stb = 2'b00;
        chk("t4_res", {res_stb, res_dat}, {1'b1, 32'h1234_5678});
        res_rdy = 1'b1;
        tick;
        res_rdy = 1'b0;
        chk("t4_done", {arg_rdy, err_rdy, res_stb}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/layer_control.md
# layer_control

Sequencer that drives a bank of UNITS associate neurons as one layer. It broadcasts each argument vector to every unit and gathers the unit results into one result vector. In training mode it scatters a per-unit error vector and collects each unit's feedback vector. It reduces the feedback into one saturated per-argument sum for the upstream layer. It sits between the upstream stream/layer and the neuron bank and owns all unit-side handshakes.

## Interface
- ARGD, 2, arguments per vector (8-bit each), matches every unit's ARGD
- UNITS, 2, number of associate units in the layer (≥1)

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset; also routed to the units
- en  in  1  training enable; sampled on argument acceptance
- arg_stb / arg_dat / arg_rdy  in / in / out  1 / 8*ARGD / 1  upstream argument vector
- res_stb / res_dat / res_rdy  out / out / in  1 / 16*UNITS / 1  layer result, unit i at [16*i +: 16]
- err_stb / err_dat / err_rdy  in / in / out  1 / 16*UNITS / 1  per-unit error, unit i at [16*i +: 16]
- fbk_stb / fbk_dat / fbk_rdy  out / out / in  1 / 16*ARGD / 1  summed feedback, arg k at [16*k +: 16]
- u_en  out  1  training enable to all units, held for the whole transaction
- u_arg_stb / u_arg_dat / u_arg_rdy  out / out / in  UNITS / 8*ARGD / UNITS  broadcast arguments
- u_res_stb / u_res_dat / u_res_rdy  in / in / out  UNITS / 16*UNITS / UNITS  unit results
- u_err_stb / u_err_dat / u_err_rdy  out / out / in  UNITS / 16*UNITS / UNITS  scattered errors
- u_fbk_stb / u_fbk_dat / u_fbk_rdy  in / in / out  UNITS / 16*ARGD*UNITS / UNITS  unit feedback, unit i at [16*ARGD*i +: 16*ARGD]

## Operation
- States: ARG, BCAST, GATHER, RES, ERR, SCAT, COLL, SUM, FBK.
- Per-unit done mask (UNITS bits) is cleared on every state entry.
- ARG: arg_rdy=1. On arg_stb, latch arg_dat into u_arg_dat, latch en into u_en, then go to BCAST.
- BCAST: u_arg_stb[i] = ~done[i]. On u_arg_stb[i]&u_arg_rdy[i], set done[i]. All done goes to GATHER.
- GATHER: u_res_rdy[i] = ~done[i]. On ack, latch u_res_dat slice i into the result register and set done[i]. All done goes to RES.
- RES: res_stb=1, held until res_rdy. On ack, go to ERR if u_en=1, otherwise go to ARG.
- ERR: err_rdy=1. On err_stb, latch err_dat into u_err_dat, then go to SCAT.
- SCAT: u_err_stb[i] = ~done[i], with the same ack/done rule as BCAST. All done goes to COLL.
- COLL: u_fbk_rdy[i] = ~done[i]. On ack, store unit i's feedback vector. All done goes to SUM.
- SUM: exactly UNITS cycles, counter 0..UNITS-1. Each cycle adds sign-extended fbk[unit cnt][k] into a 24-bit accumulator per k. The accumulators are zeroed on SUM entry.
- SUM saturation: on exit each sum is clamped to [0x8000, 0x7FFF] and written to fbk_dat. Go to FBK.
- FBK: fbk_stb=1 until fbk_rdy. On ack, go to ARG.
- Simultaneous unit acks in one cycle are all accepted. Order of unit completion is irrelevant.
- Reset (async, any state) clears:
  - state to ARG, all masks, counter and accumulators
  - all strobes/readies to 0, except arg_rdy=1 from ARG
  - u_en, res_dat and fbk_dat to 0
- An in-flight transaction is discarded on reset. No partial output is emitted.

## Timing
- arg_rdy, err_rdy, u_*_rdy and u_*_stb are combinational from state and mask. res_stb and fbk_stb are registered.
- Argument accepted at edge N: u_arg_stb=all-ones from cycle N+1.
- A unit acked at edge M drops its strobe/ready from cycle M+1.
- Last u_res ack at edge M: res_stb=1 from cycle M+1.
- Last u_fbk ack at edge M: SUM occupies cycles M+1..M+UNITS. fbk_stb=1 from cycle M+UNITS+1.
- res_dat and fbk_dat are stable while their strobe is high. Strobes deassert the cycle after ack.
- arg_stb is ignored outside ARG, and err_stb is ignored outside ERR. Upstream must hold its strobe.
- u_arg_dat, u_err_dat and u_en are stable from latch until the next ARG acceptance.

## Test plan
- UNITS=2, ARGD=2, en=0, arg 0x0201. Units ack u_arg in cycles 1 and 3 and return results 0x0010 and 0xFFF0 -> res_dat=0xFFF00010, res_stb rises once, return to ARG with no err_rdy.
- en=1 full pass. Error 0x00400020 reaches unit0=0x0020 and unit1=0x0040. Feedback unit0 {k1=0x0100, k0=0x0001}, unit1 {0x0200, 0x0003} -> fbk_dat=0x03000004, fbk_stb rises 2 cycles after last u_fbk ack.
- Saturation. k0: 0x7000+0x2000 -> 0x7FFF. k1: 0x8000+0xFFFF -> 0x8000.
- Back-pressure. Hold res_rdy=0 for 10 cycles, then do the same for fbk_rdy -> strobes and data held constant, no extra unit handshakes.
- Simultaneous acks. Both units ack u_res in the same cycle -> both latched, RES next cycle. Unit1 acks before unit0 -> identical res_dat.
- Reset asserted mid-SCAT with unit0 acked and unit1 pending -> all unit strobes 0 immediately, arg_rdy=1. The next transaction completes normally.
